// File: rtl/layer_output_collector_if.sv
// Handshake bundle between a neuron result stream and the downstream layer.
//   in_valid/in_data/in_ready    : neuron result offer and acceptance
//   vec_out/vec_valid/vec_ready  : completed activation vector handoff
//   count                        : results held in the vector being built
//   overflow                     : sticky "result offered while not ready"
// Modports: master = producer/consumer side (testbench or neighbouring layers),
//           slave  = the collector itself.
interface layer_output_collector_if #(
  parameter int NUM_NEURONS = 3,
  parameter int DATA_WIDTH  = 16
);
  localparam int CountWidth = $clog2(NUM_NEURONS + 1);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] vec_out [NUM_NEURONS];
  logic                         vec_valid;
  logic                         vec_ready;
  logic [CountWidth-1:0]        count;
  logic                         overflow;

  modport master (
    output in_valid, in_data, vec_ready,
    input  in_ready, vec_out, vec_valid, count, overflow
  );

  modport slave (
    input  in_valid, in_data, vec_ready,
    output in_ready, vec_out, vec_valid, count, overflow
  );
endinterface

// File: rtl/layer_output_collector.sv
// Gathers NUM_NEURONS neuron results into one activation vector.
// Each accepted result is arithmetically shifted right by SHIFT and, when the
// macro LAYER_COLLECT_RELU_EN is defined, clamped at zero (ReLU) before being
// stored. Once the vector is full it is presented with vec_valid until the
// downstream layer takes it with vec_ready.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : layer_output_collector_if.slave (input stream, vector handoff,
//           count and sticky overflow flag)
module layer_output_collector #(
  parameter int NUM_NEURONS = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT       = 0
) (
  input logic                      clk,
  input logic                      rst_n,
  layer_output_collector_if.slave  bus
);

  localparam int CountWidth = $clog2(NUM_NEURONS + 1);
  localparam logic [CountWidth-1:0] LastIdx = CountWidth'(NUM_NEURONS - 1);

  typedef enum logic [0:0] {StCollect, StFull} state_e;

  state_e                       r_state, w_state_next;
  logic [CountWidth-1:0]        r_count, w_count_next;
  logic signed [DATA_WIDTH-1:0] r_vec [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0] w_vec_next [NUM_NEURONS];
  logic                         r_overflow, w_overflow_next;
  logic signed [DATA_WIDTH-1:0] w_shifted, w_processed;

  assign w_shifted = bus.in_data >>> SHIFT;

`ifdef LAYER_COLLECT_RELU_EN
  assign w_processed = w_shifted[DATA_WIDTH-1] ? '0 : w_shifted;
`else
  assign w_processed = w_shifted;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_vec_next      = r_vec;
    w_overflow_next = r_overflow;
    unique case (r_state)
      StCollect: begin
        // vec_ready is irrelevant here; only a full vector can be handed off
        if (bus.in_valid) begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            if (r_count == CountWidth'(i)) w_vec_next[i] = w_processed;
          end
          w_count_next = r_count + CountWidth'(1);
          if (r_count == LastIdx) w_state_next = StFull;
        end
      end
      StFull: begin
        // Any offer while full is dropped, including the handoff cycle
        if (bus.in_valid) w_overflow_next = 1'b1;
        if (bus.vec_ready) begin
          w_state_next = StCollect;
          w_count_next = '0;
        end
      end
      default: w_state_next = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StCollect;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) r_vec[i] <= '0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_overflow <= w_overflow_next;
      r_vec      <= w_vec_next;
    end
  end

  assign bus.in_ready  = (r_state == StCollect);
  assign bus.vec_valid = (r_state == StFull);
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.vec_out   = r_vec;

endmodule

// File: tb/tb_layer_output_collector.sv
// Directed bench for layer_output_collector: a per-cycle vector table on a
// SHIFT=0 instance, plus sequences for the shifted instance and back-to-back
// streaming. Expected values follow LAYER_COLLECT_RELU_EN when defined.
module tb_layer_output_collector;

`ifdef LAYER_COLLECT_RELU_EN
  localparam int NegE   = 0;  // -20 after ReLU
  localparam int ShNegE = 0;  // -7 >>> 2 = -2, after ReLU
`else
  localparam int NegE   = -20;
  localparam int ShNegE = -2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_output_collector_if #(.NUM_NEURONS(3), .DATA_WIDTH(16)) bus0 ();
  layer_output_collector_if #(.NUM_NEURONS(3), .DATA_WIDTH(16)) bus2 ();

  layer_output_collector #(.NUM_NEURONS(3), .DATA_WIDTH(16), .SHIFT(0)) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0.slave)
  );

  layer_output_collector #(.NUM_NEURONS(3), .DATA_WIDTH(16), .SHIFT(2)) u_dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2.slave)
  );

  typedef struct {
    bit rst_n;
    bit in_valid;
    int in_data;
    bit vec_ready;
    bit e_ready;
    bit e_valid;
    int e_count;
    bit e_ov;
    int e_v0;
    int e_v1;
    int e_v2;
  } row_t;

  row_t rows[$];
  int   tests = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit v, input int d, input bit vr, input bit er,
                     input bit ev, input int ec, input bit eo, input int a, input int b,
                     input int c);
    row_t t;
    t = '{r, v, d, vr, er, ev, ec, eo, a, b, c};
    rows.push_back(t);
  endtask

  int sent;
  int nvec;
  int got [2][3];
  int vcyc [2];

  initial begin
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.vec_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.vec_ready = 1'b0;

    //  rst v  data vr | rdy vld cnt ov  v0  v1  v2
    add(0, 1, 5,   0,   1,  0,  0,  0,  0,  0,  0);     // reset state, offer ignored
    add(1, 1, 66,  0,   1,  0,  1,  0,  66, 0,  0);
    add(1, 1, 90,  0,   1,  0,  2,  0,  66, 90, 0);
    add(1, 1, -20, 0,   0,  1,  3,  0,  66, 90, NegE);  // full one cycle after 3rd accept
    add(1, 0, 0,   0,   0,  1,  3,  0,  66, 90, NegE);  // backpressure hold
    add(1, 1, 115, 0,   0,  1,  3,  1,  66, 90, NegE);  // dropped, overflow set
    add(1, 0, 0,   0,   0,  1,  3,  1,  66, 90, NegE);
    add(1, 0, 0,   0,   0,  1,  3,  1,  66, 90, NegE);
    add(1, 0, 0,   0,   0,  1,  3,  1,  66, 90, NegE);
    add(1, 0, 0,   1,   1,  0,  0,  1,  66, 90, NegE);  // handoff, stale data kept
    add(1, 0, 0,   1,   1,  0,  0,  1,  66, 90, NegE);  // vec_ready ignored in collect
    add(1, 1, 15,  1,   1,  0,  1,  1,  15, 90, NegE);
    add(1, 1, 20,  0,   1,  0,  2,  1,  15, 20, NegE);
    add(0, 1, 99,  0,   1,  0,  0,  0,  0,  0,  0);     // mid-collection reset
    add(1, 1, 1,   0,   1,  0,  1,  0,  1,  0,  0);
    add(1, 1, 2,   0,   1,  0,  2,  0,  1,  2,  0);
    add(1, 1, 3,   0,   0,  1,  3,  0,  1,  2,  3);
    add(1, 1, 50,  1,   1,  0,  0,  1,  1,  2,  3);     // offer on handoff edge dropped

    foreach (rows[i]) begin
      @(negedge clk);
      rst_n          = rows[i].rst_n;
      bus0.in_valid  = rows[i].in_valid;
      bus0.in_data   = 16'(rows[i].in_data);
      bus0.vec_ready = rows[i].vec_ready;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d in_ready", i), int'(bus0.in_ready), int'(rows[i].e_ready));
      chk($sformatf("row%0d vec_valid", i), int'(bus0.vec_valid), int'(rows[i].e_valid));
      chk($sformatf("row%0d count", i), int'(bus0.count), rows[i].e_count);
      chk($sformatf("row%0d overflow", i), int'(bus0.overflow), int'(rows[i].e_ov));
      chk($sformatf("row%0d vec0", i), int'(bus0.vec_out[0]), rows[i].e_v0);
      chk($sformatf("row%0d vec1", i), int'(bus0.vec_out[1]), rows[i].e_v1);
      chk($sformatf("row%0d vec2", i), int'(bus0.vec_out[2]), rows[i].e_v2);
    end

    // SHIFT=2 instance: 13, -7, 4 -> 3, -2, 1
    @(negedge clk);
    rst_n = 1'b0; bus0.in_valid = 1'b0; bus0.vec_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus2.in_valid = 1'b1; bus2.in_data = 16'sd13;
    @(negedge clk);
    bus2.in_data = -16'sd7;
    @(negedge clk);
    bus2.in_data = 16'sd4;
    @(posedge clk);
    #1;
    chk("shift vec_valid", int'(bus2.vec_valid), 1);
    chk("shift count", int'(bus2.count), 3);
    chk("shift vec0", int'(bus2.vec_out[0]), 3);
    chk("shift vec1", int'(bus2.vec_out[1]), ShNegE);
    chk("shift vec2", int'(bus2.vec_out[2]), 1);
    @(negedge clk);
    bus2.in_valid = 1'b0;

    // Back-to-back vectors with vec_ready tied high
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus0.vec_ready = 1'b1;
    sent = 0;
    nvec = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (bus0.in_ready && sent < 6) begin
        bus0.in_valid = 1'b1;
        bus0.in_data  = 16'(sent + 1);
        sent++;
      end else begin
        bus0.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus0.vec_valid) begin
        if (nvec < 2) begin
          for (int k = 0; k < 3; k++) got[nvec][k] = int'(bus0.vec_out[k]);
          vcyc[nvec] = cyc;
        end
        nvec++;
      end
    end
    chk("b2b vectors seen", nvec, 2);
    chk("b2b results sent", sent, 6);
    chk("b2b first full cycle", vcyc[0], 2);
    chk("b2b second full cycle", vcyc[1], 6);
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < 3; k++)
        chk($sformatf("b2b vec%0d[%0d]", v, k), got[v][k], v * 3 + k + 1);
    chk("b2b overflow", int'(bus0.overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
